// File: rtl/frame_sequencer.sv
// -----------------------------------------------------------------------------
// frame_sequencer
//
// Purpose:
//   Turns the display vertical-blank pulse into the per-frame update strobe
//   pair (new_frame, then new_frame2 one cycle later) for the game block. It
//   also conditions the raw push-button into a single-cycle press strobe that
//   is never emitted during either update strobe. A sticky overrun flag is
//   raised when an update trigger arrives before the previous update has
//   settled.
//
// Optional feature (macro FRAME_STEP_EN):
//   When defined, adds step_mode / step_req. With step_mode=1 a trigger only
//   issues an update if a step token (set by step_req) is held. With the macro
//   undefined those ports do not exist and every trigger is handled normally.
//
// Ports:
//   clk           in   system clock
//   rstn          in   asynchronous active-low reset
//   vsync_start   in   one-cycle pulse at start of vertical blank
//   button_raw    in   raw asynchronous push-button, active-high
//   overrun_clr   in   one-cycle pulse, clears overrun
//   step_mode     in   (FRAME_STEP_EN only) single-step mode level
//   step_req      in   (FRAME_STEP_EN only) one-cycle step request
//   new_frame     out  one-cycle strobe, game state register update
//   new_frame2    out  one-cycle strobe, one cycle after new_frame
//   button_pulse  out  one-cycle debounced press strobe
//   frame_ready   out  high while the sequencer is idle
//   frame_count   out  number of updates issued, wraps at 16 bits
//   overrun       out  sticky, trigger arrived while not idle
// -----------------------------------------------------------------------------
module frame_sequencer #(
  parameter int unsigned FRAME_DIV       = 1,
  parameter int unsigned SETTLE_CYCLES   = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned DB_W            = 18
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        vsync_start,
  input  logic        button_raw,
  input  logic        overrun_clr,
`ifdef FRAME_STEP_EN
  input  logic        step_mode,
  input  logic        step_req,
`endif
  output logic        new_frame,
  output logic        new_frame2,
  output logic        button_pulse,
  output logic        frame_ready,
  output logic [15:0] frame_count,
  output logic        overrun
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_NF1    = 2'd1,
    ST_NF2    = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  localparam logic [3:0]      DIV_LAST    = 4'(FRAME_DIV - 32'd1);
  localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_CYCLES - 32'd1);
  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [DB_W-1:0] DB_ONE      = DB_W'(32'd1);
  localparam logic [DB_W-1:0] DB_ZERO     = DB_W'(32'd0);

  // ---------------------------------------------------------------------------
  // Divider
  // ---------------------------------------------------------------------------
  logic [3:0] div_q, div_d;
  logic       trigger_s;
  logic       go_s;

  assign trigger_s = vsync_start && (div_q == DIV_LAST);

  // Next divider count: advance on each vsync pulse, wrap after the last one.
  always_comb begin
    div_d = div_q;
    if (vsync_start) begin
      if (div_q == DIV_LAST) begin
        div_d = 4'd0;
      end else begin
        div_d = div_q + 4'd1;
      end
    end else begin
      div_d = div_q;
    end
  end

  // Divider register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q <= 4'd0;
    end else begin
      div_q <= div_d;
    end
  end

`ifdef FRAME_STEP_EN
  // ---------------------------------------------------------------------------
  // Single-step token: a trigger in step mode is only acted on while a token
  // is held. Ignored triggers never reach the FSM, so they cannot raise overrun.
  // ---------------------------------------------------------------------------
  logic token_q, token_d;

  assign go_s = trigger_s && (!step_mode || token_q);

  // Next token state: cleared outside step mode, set by step_req, spent by a trigger.
  always_comb begin
    token_d = token_q;
    if (!step_mode) begin
      token_d = 1'b0;
    end else if (step_req) begin
      token_d = 1'b1;
    end else if (trigger_s && token_q) begin
      token_d = 1'b0;
    end else begin
      token_d = token_q;
    end
  end

  // Step token register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      token_q <= 1'b0;
    end else begin
      token_q <= token_d;
    end
  end
`else
  assign go_s = trigger_s;
`endif

  // ---------------------------------------------------------------------------
  // Update FSM with registered strobes
  // ---------------------------------------------------------------------------
  state_t      state_q;
  logic [7:0]  settle_q;
  logic        new_frame_q;
  logic        new_frame2_q;
  logic        frame_ready_q;
  logic [15:0] count_q;

  // Update sequencing: IDLE -> NF1 -> NF2 -> (SETTLE) -> IDLE, outputs registered with the state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      settle_q      <= 8'd0;
      new_frame_q   <= 1'b0;
      new_frame2_q  <= 1'b0;
      frame_ready_q <= 1'b1;
      count_q       <= 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go_s) begin
            state_q       <= ST_NF1;
            new_frame_q   <= 1'b1;
            frame_ready_q <= 1'b0;
            count_q       <= count_q + 16'd1;
          end else begin
            state_q       <= ST_IDLE;
          end
        end
        ST_NF1: begin
          state_q      <= ST_NF2;
          new_frame_q  <= 1'b0;
          new_frame2_q <= 1'b1;
        end
        ST_NF2: begin
          new_frame2_q <= 1'b0;
          settle_q     <= 8'd0;
          if (SETTLE_CYCLES > 32'd0) begin
            state_q       <= ST_SETTLE;
          end else begin
            state_q       <= ST_IDLE;
            frame_ready_q <= 1'b1;
          end
        end
        ST_SETTLE: begin
          // SETTLE occupies exactly SETTLE_CYCLES cycles.
          if (settle_q == SETTLE_LAST) begin
            state_q       <= ST_IDLE;
            frame_ready_q <= 1'b1;
          end else begin
            settle_q      <= settle_q + 8'd1;
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          new_frame_q   <= 1'b0;
          new_frame2_q  <= 1'b0;
          frame_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Overrun flag: set wins over clear
  // ---------------------------------------------------------------------------
  logic overrun_q, overrun_d;
  logic overrun_set_s;

  assign overrun_set_s = go_s && (state_q != ST_IDLE);

  // Next overrun value.
  always_comb begin
    overrun_d = overrun_q;
    if (overrun_set_s) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Overrun register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Button path: synchronizer, debouncer, pending press, emission
  // ---------------------------------------------------------------------------
  logic            sync1_q, sync2_q;
  logic            db_level_q, db_level_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            rise_s;
  logic            pending_q, pending_d;
  logic            button_pulse_q;
  logic            busy_next_s;
  logic            emit_s;

  // Next debouncer state: accept the synchronized level after DEBOUNCE_CYCLES consecutive differing cycles.
  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = db_cnt_q;
    rise_s     = 1'b0;
    if (sync2_q != db_level_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_level_d = sync2_q;
        db_cnt_d   = DB_ZERO;
        rise_s     = sync2_q;
      end else begin
        db_cnt_d   = db_cnt_q + DB_ONE;
      end
    end else begin
      db_cnt_d = DB_ZERO;
    end
  end

  // The strobe register is loaded from the next state, so emission looks at
  // whether the FSM is about to enter NF1/NF2; this keeps button_pulse off
  // both strobe cycles, including the one right after a trigger.
  assign busy_next_s = ((state_q == ST_IDLE) && go_s) || (state_q == ST_NF1);
  assign emit_s      = pending_q && !busy_next_s;

  // Next pending flag: a new press sets it (merging with any press already held), emission clears it.
  always_comb begin
    pending_d = pending_q;
    if (rise_s) begin
      pending_d = 1'b1;
    end else if (emit_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // Button path registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      db_level_q     <= 1'b0;
      db_cnt_q       <= DB_ZERO;
      pending_q      <= 1'b0;
      button_pulse_q <= 1'b0;
    end else begin
      sync1_q        <= button_raw;
      sync2_q        <= sync1_q;
      db_level_q     <= db_level_d;
      db_cnt_q       <= db_cnt_d;
      pending_q      <= pending_d;
      button_pulse_q <= emit_s;
    end
  end

  assign new_frame    = new_frame_q;
  assign new_frame2   = new_frame2_q;
  assign button_pulse = button_pulse_q;
  assign frame_ready  = frame_ready_q;
  assign frame_count  = count_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_frame_sequencer
//
// Directed bench for frame_sequencer. Three instances with different
// parameters share one clock and reset:
//   u_a : FRAME_DIV=1, SETTLE_CYCLES=8,  DEBOUNCE_CYCLES=4 (latency, button)
//   u_b : FRAME_DIV=3, SETTLE_CYCLES=2,  DEBOUNCE_CYCLES=4 (divider)
//   u_c : FRAME_DIV=1, SETTLE_CYCLES=20, DEBOUNCE_CYCLES=4 (overrun, step)
// Inputs are driven 1 time unit after the rising edge and outputs are sampled
// at the same point, i.e. "cycle t" is the clock period in which an input is
// held high and its registered effect is visible in cycle t+1.
// -----------------------------------------------------------------------------
module tb_frame_sequencer;

  logic clk;
  logic rstn;

  logic vs_a, btn_a, clr_a, nf_a, nf2_a, bp_a, fr_a, ov_a;
  logic vs_b, btn_b, clr_b, nf_b, nf2_b, bp_b, fr_b, ov_b;
  logic vs_c, btn_c, clr_c, nf_c, nf2_c, bp_c, fr_c, ov_c;
  logic [15:0] fc_a, fc_b, fc_c;
`ifdef FRAME_STEP_EN
  logic sm_a, sr_a, sm_b, sr_b, sm_c, sr_c;
`endif

  int n_vec;
  int n_err;

  frame_sequencer #(.FRAME_DIV(1), .SETTLE_CYCLES(8), .DEBOUNCE_CYCLES(4), .DB_W(3)) u_a (
    .clk(clk), .rstn(rstn), .vsync_start(vs_a), .button_raw(btn_a), .overrun_clr(clr_a),
`ifdef FRAME_STEP_EN
    .step_mode(sm_a), .step_req(sr_a),
`endif
    .new_frame(nf_a), .new_frame2(nf2_a), .button_pulse(bp_a), .frame_ready(fr_a),
    .frame_count(fc_a), .overrun(ov_a)
  );

  frame_sequencer #(.FRAME_DIV(3), .SETTLE_CYCLES(2), .DEBOUNCE_CYCLES(4), .DB_W(3)) u_b (
    .clk(clk), .rstn(rstn), .vsync_start(vs_b), .button_raw(btn_b), .overrun_clr(clr_b),
`ifdef FRAME_STEP_EN
    .step_mode(sm_b), .step_req(sr_b),
`endif
    .new_frame(nf_b), .new_frame2(nf2_b), .button_pulse(bp_b), .frame_ready(fr_b),
    .frame_count(fc_b), .overrun(ov_b)
  );

  frame_sequencer #(.FRAME_DIV(1), .SETTLE_CYCLES(20), .DEBOUNCE_CYCLES(4), .DB_W(3)) u_c (
    .clk(clk), .rstn(rstn), .vsync_start(vs_c), .button_raw(btn_c), .overrun_clr(clr_c),
`ifdef FRAME_STEP_EN
    .step_mode(sm_c), .step_req(sr_c),
`endif
    .new_frame(nf_c), .new_frame2(nf2_c), .button_pulse(bp_c), .frame_ready(fr_c),
    .frame_count(fc_c), .overrun(ov_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    tick();
    n_vec++; if (nf_a !== 1'b0) begin $display("FAIL reset_new_frame: got %b want 0", nf_a); n_err++; end
    n_vec++; if (nf2_a !== 1'b0) begin $display("FAIL reset_new_frame2: got %b want 0", nf2_a); n_err++; end
    n_vec++; if (bp_a !== 1'b0) begin $display("FAIL reset_button_pulse: got %b want 0", bp_a); n_err++; end
    n_vec++; if (fr_a !== 1'b1) begin $display("FAIL reset_frame_ready: got %b want 1", fr_a); n_err++; end
    n_vec++; if (fc_a !== 16'd0) begin $display("FAIL reset_frame_count: got %0d want 0", fc_a); n_err++; end
    n_vec++; if (ov_a !== 1'b0) begin $display("FAIL reset_overrun: got %b want 0", ov_a); n_err++; end
    n_vec++; if ({fr_b, fr_c} !== 2'b11) begin $display("FAIL reset_frame_ready_bc: got %b want 11", {fr_b, fr_c}); n_err++; end
    rstn = 1'b1;
    tick();
    tick();
  endtask

  // Trigger in cycle t: new_frame @t+1, new_frame2 @t+2, frame_ready low t+1..t+10, high @t+11.
  task automatic test_single_update();
    logic exp_nf, exp_nf2, exp_fr;
    vs_a = 1'b1;
    tick();
    vs_a = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      exp_nf  = (k == 1);
      exp_nf2 = (k == 2);
      exp_fr  = (k >= 11);
      n_vec++; if (nf_a !== exp_nf) begin $display("FAIL single_new_frame t+%0d: got %b want %b", k, nf_a, exp_nf); n_err++; end
      n_vec++; if (nf2_a !== exp_nf2) begin $display("FAIL single_new_frame2 t+%0d: got %b want %b", k, nf2_a, exp_nf2); n_err++; end
      n_vec++; if (fr_a !== exp_fr) begin $display("FAIL single_frame_ready t+%0d: got %b want %b", k, fr_a, exp_fr); n_err++; end
      tick();
    end
    n_vec++; if (fc_a !== 16'd1) begin $display("FAIL single_frame_count: got %0d want 1", fc_a); n_err++; end
  endtask

  // FRAME_DIV=3: only pulses 3 and 6 of 7 produce an update.
  task automatic test_divider();
    logic exp_upd;
    for (int p = 1; p <= 7; p++) begin
      exp_upd = ((p % 3) == 0);
      vs_b = 1'b1;
      tick();
      vs_b = 1'b0;
      n_vec++; if (nf_b !== exp_upd) begin $display("FAIL div_new_frame pulse%0d: got %b want %b", p, nf_b, exp_upd); n_err++; end
      tick();
      n_vec++; if (nf2_b !== exp_upd) begin $display("FAIL div_new_frame2 pulse%0d: got %b want %b", p, nf2_b, exp_upd); n_err++; end
      repeat (8) tick();
    end
    n_vec++; if (fc_b !== 16'd2) begin $display("FAIL div_frame_count: got %0d want 2", fc_b); n_err++; end
    n_vec++; if (ov_b !== 1'b0) begin $display("FAIL div_overrun: got %b want 0", ov_b); n_err++; end
  endtask

  // SETTLE_CYCLES=20, second trigger 9 cycles later is dropped and raises overrun.
  task automatic test_overrun();
    vs_c = 1'b1;
    tick();
    vs_c = 1'b0;
    repeat (8) tick();
    vs_c = 1'b1;
    tick();
    vs_c = 1'b0;
    n_vec++; if (ov_c !== 1'b1) begin $display("FAIL ovr_set: got %b want 1", ov_c); n_err++; end
    n_vec++; if (nf_c !== 1'b0) begin $display("FAIL ovr_no_strobe: got %b want 0", nf_c); n_err++; end
    repeat (15) tick();
    n_vec++; if (fc_c !== 16'd1) begin $display("FAIL ovr_frame_count: got %0d want 1", fc_c); n_err++; end
    n_vec++; if (fr_c !== 1'b1) begin $display("FAIL ovr_frame_ready: got %b want 1", fr_c); n_err++; end
    n_vec++; if (ov_c !== 1'b1) begin $display("FAIL ovr_sticky: got %b want 1", ov_c); n_err++; end
    clr_c = 1'b1;
    tick();
    clr_c = 1'b0;
    n_vec++; if (ov_c !== 1'b0) begin $display("FAIL ovr_clear: got %b want 0", ov_c); n_err++; end
    // Set and clear in the same cycle (trigger during NF1): set wins.
    vs_c = 1'b1;
    tick();
    vs_c = 1'b1;
    clr_c = 1'b1;
    tick();
    vs_c = 1'b0;
    clr_c = 1'b0;
    n_vec++; if (ov_c !== 1'b1) begin $display("FAIL ovr_set_wins: got %b want 1", ov_c); n_err++; end
    n_vec++; if (nf2_c !== 1'b1) begin $display("FAIL ovr_nf2_intact: got %b want 1", nf2_c); n_err++; end
    n_vec++; if (fc_c !== 16'd2) begin $display("FAIL ovr_count_after_drop: got %0d want 2", fc_c); n_err++; end
    repeat (25) tick();
    clr_c = 1'b1;
    tick();
    clr_c = 1'b0;
    n_vec++; if (ov_c !== 1'b0) begin $display("FAIL ovr_clear2: got %b want 0", ov_c); n_err++; end
  endtask

  // DEBOUNCE_CYCLES=4: 1-0-1 bounce then hold gives one pulse 7 cycles after the final rise; release gives none.
  task automatic test_button();
    int pulses;
    int first_at;
    btn_a = 1'b1; tick(); tick();
    btn_a = 1'b0; tick(); tick();
    btn_a = 1'b1;
    pulses = 0;
    first_at = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bp_a === 1'b1) begin
        pulses++;
        if (first_at == 0) first_at = k;
      end
    end
    n_vec++; if (pulses != 1) begin $display("FAIL btn_press_count: got %0d want 1", pulses); n_err++; end
    n_vec++; if (first_at != 7) begin $display("FAIL btn_press_latency: got %0d want 7", first_at); n_err++; end
    btn_a = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bp_a === 1'b1) pulses++;
    end
    n_vec++; if (pulses != 0) begin $display("FAIL btn_release_count: got %0d want 0", pulses); n_err++; end
  endtask

  // Press pending in the trigger cycle is held through NF1/NF2 and emitted at t+3.
  task automatic test_defer();
    logic exp_bp;
    btn_a = 1'b1;
    repeat (6) tick();
    vs_a = 1'b1;
    tick();
    vs_a = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      exp_bp = (k == 3);
      n_vec++; if (bp_a !== exp_bp) begin $display("FAIL defer_button_pulse t+%0d: got %b want %b", k, bp_a, exp_bp); n_err++; end
      if (k == 1) begin
        n_vec++; if (nf_a !== 1'b1) begin $display("FAIL defer_new_frame: got %b want 1", nf_a); n_err++; end
      end
      if (k == 2) begin
        n_vec++; if (nf2_a !== 1'b1) begin $display("FAIL defer_new_frame2: got %b want 1", nf2_a); n_err++; end
      end
      tick();
    end
    btn_a = 1'b0;
    repeat (20) tick();
    n_vec++; if (fc_a !== 16'd2) begin $display("FAIL defer_frame_count: got %0d want 2", fc_a); n_err++; end
  endtask

`ifdef FRAME_STEP_EN
  // Step mode: 5 triggers, one step_req after the 2nd -> only the 3rd issues an update.
  task automatic test_step();
    int ups;
    sm_c = 1'b1;
    ups = 0;
    for (int p = 1; p <= 5; p++) begin
      vs_c = 1'b1;
      tick();
      vs_c = 1'b0;
      if (nf_c === 1'b1) ups++;
      n_vec++; if (nf_c !== (p == 3)) begin $display("FAIL step_new_frame pulse%0d: got %b want %b", p, nf_c, (p == 3)); n_err++; end
      repeat (5) tick();
      if (p == 2) begin
        sr_c = 1'b1;
        tick();
        sr_c = 1'b0;
      end
      repeat (24) tick();
    end
    sm_c = 1'b0;
    n_vec++; if (ups != 1) begin $display("FAIL step_updates: got %0d want 1", ups); n_err++; end
    n_vec++; if (fc_c !== 16'd3) begin $display("FAIL step_frame_count: got %0d want 3", fc_c); n_err++; end
    n_vec++; if (ov_c !== 1'b0) begin $display("FAIL step_overrun: got %b want 0", ov_c); n_err++; end
  endtask
`endif

  // Reset asserted during NF1 clears everything at once and no new_frame2 follows.
  task automatic test_reset_mid();
    vs_a = 1'b1;
    tick();
    vs_a = 1'b0;
    n_vec++; if (nf_a !== 1'b1) begin $display("FAIL rmid_in_nf1: got %b want 1", nf_a); n_err++; end
    #2;
    rstn = 1'b0;
    #1;
    n_vec++; if (nf_a !== 1'b0) begin $display("FAIL rmid_new_frame: got %b want 0", nf_a); n_err++; end
    n_vec++; if (fr_a !== 1'b1) begin $display("FAIL rmid_frame_ready: got %b want 1", fr_a); n_err++; end
    n_vec++; if (fc_a !== 16'd0) begin $display("FAIL rmid_frame_count: got %0d want 0", fc_a); n_err++; end
    tick();
    rstn = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_vec++; if ({nf_a, nf2_a} !== 2'b00) begin $display("FAIL rmid_no_strobe c%0d: got %b want 00", k, {nf_a, nf2_a}); n_err++; end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rstn  = 1'b0;
    vs_a = 1'b0; btn_a = 1'b0; clr_a = 1'b0;
    vs_b = 1'b0; btn_b = 1'b0; clr_b = 1'b0;
    vs_c = 1'b0; btn_c = 1'b0; clr_c = 1'b0;
`ifdef FRAME_STEP_EN
    sm_a = 1'b0; sr_a = 1'b0;
    sm_b = 1'b0; sr_b = 1'b0;
    sm_c = 1'b0; sr_c = 1'b0;
`endif
    test_reset();
    test_single_update();
    test_divider();
    test_overrun();
    test_button();
    test_defer();
`ifdef FRAME_STEP_EN
    test_step();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
